// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the instruction-fetch stage.
//   fetch_state_t : FSM state encoding (RUN, HALT)
//   PC_INC        : byte increment between sequential fetches
//   HALT_WORD     : instruction word that stops fetching
//   BUBBLE        : instruction value loaded into IF/ID for a squashed slot
package fetch_pkg;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

    localparam int unsigned PC_INC    = 4;
    localparam logic [31:0] HALT_WORD = 32'h0000_0000;
    localparam logic [31:0] BUBBLE    = 32'h0000_0000;

endpackage

// File: rtl/flopenr.sv
// flopenr: parameterised-width register with enable, synchronous clear and
// asynchronous active-high reset.
//   clk       : clock, rising edge
//   reset     : asynchronous active-high reset, forces q to zero
//   en        : load d on the rising edge
//   clr       : load CLR_VALUE on the rising edge; overrides en
//   d         : data in
//   q         : registered data out
module flopenr #(
    parameter int unsigned            WIDTH     = 8,
    parameter logic [WIDTH-1:0]       CLR_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (clr) begin
            q <= CLR_VALUE;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage with PC register, RUN/HALT FSM, IF/ID
// pipeline register and a delivered-instruction counter.
//   clk         : clock, rising edge
//   reset       : asynchronous active-high reset
//   PCSrc_F     : redirect request; PC loads PCBranch_F (word aligned)
//   PCBranch_F  : redirect target byte address
//   stall       : hold PC, IF/ID and FSM
//   flush       : load bubble into IF/ID
//   imem_addr   : word address to instruction memory (PC[7:2])
//   imem_q      : instruction word from instruction memory (combinational)
//   pc_F        : current fetch PC
//   instr_D     : IF/ID instruction
//   pc_D        : IF/ID PC of instr_D
//   valid_D     : IF/ID holds a real instruction
//   halted      : FSM is in HALT
//   fetch_count : number of instructions delivered with valid_D=1
module if_stage
    import fetch_pkg::*;
#(
    parameter int unsigned N = 64,
    parameter int unsigned I = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         PCSrc_F,
    input  logic [N-1:0] PCBranch_F,
    input  logic         stall,
    input  logic         flush,
    output logic [5:0]   imem_addr,
    input  logic [I-1:0] imem_q,
    output logic [N-1:0] pc_F,
    output logic [I-1:0] instr_D,
    output logic [N-1:0] pc_D,
    output logic         valid_D,
    output logic         halted,
    output logic [31:0]  fetch_count
);

    localparam int unsigned IFID_W = I + N + 1;

    fetch_state_t      state;
    logic              run;
    logic              halt_hit;
    logic              advance;
    logic              deliver;
    logic              ifid_clr;
    logic [N-1:0]      pc_next;
    logic [IFID_W-1:0] ifid_d;
    logic [IFID_W-1:0] ifid_q;

    // Addresses past 256 bytes alias onto the 64-word memory.
    assign imem_addr = pc_F[7:2];

    always_comb begin
        run      = (state == RUN);
        // The halt word is only recognised on a fetch that would otherwise proceed.
        halt_hit = run && !stall && !PCSrc_F && (imem_q == I'(HALT_WORD));
        advance  = run && !stall && !PCSrc_F && !halt_hit;
        deliver  = advance && !flush;
        // In HALT the register keeps reloading the bubble.
        ifid_clr = PCSrc_F || flush || halt_hit || !run;

        if (PCSrc_F) begin
            pc_next = PCBranch_F & ~N'(3);
        end else if (advance) begin
            pc_next = pc_F + N'(PC_INC);
        end else begin
            pc_next = pc_F;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= RUN;
            halted      <= 1'b0;
            pc_F        <= '0;
            fetch_count <= '0;
        end else begin
            pc_F <= pc_next;
            if (deliver) begin
                fetch_count <= fetch_count + 32'd1;
            end
            case (state)
                RUN: begin
                    if (halt_hit) begin
                        state  <= HALT;
                        halted <= 1'b1;
                    end
                end
                HALT: begin
                    if (PCSrc_F) begin
                        state  <= RUN;
                        halted <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign ifid_d = {1'b1, pc_F, imem_q};

    flopenr #(
        .WIDTH     (IFID_W),
        .CLR_VALUE ({1'b0, {N{1'b0}}, I'(BUBBLE)})
    ) u_ifid (
        .clk   (clk),
        .reset (reset),
        .en    (deliver),
        .clr   (ifid_clr),
        .d     (ifid_d),
        .q     (ifid_q)
    );

    assign valid_D = ifid_q[IFID_W-1];
    assign pc_D    = ifid_q[IFID_W-2:I];
    assign instr_D = ifid_q[I-1:0];

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed and randomized checks of if_stage against a
// behavioural fetch model kept in the bench.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        PCSrc_F = 1'b0;
    logic [63:0] PCBranch_F = '0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [5:0]  imem_addr;
    logic [31:0] imem_q;
    logic [63:0] pc_F;
    logic [31:0] instr_D;
    logic [63:0] pc_D;
    logic        valid_D;
    logic        halted;
    logic [31:0] fetch_count;

    logic [31:0] mem [0:63];

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    assign imem_q = mem[imem_addr];

    if_stage #(
        .N (64),
        .I (32)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .PCSrc_F     (PCSrc_F),
        .PCBranch_F  (PCBranch_F),
        .stall       (stall),
        .flush       (flush),
        .imem_addr   (imem_addr),
        .imem_q      (imem_q),
        .pc_F        (pc_F),
        .instr_D     (instr_D),
        .pc_D        (pc_D),
        .valid_D     (valid_D),
        .halted      (halted),
        .fetch_count (fetch_count)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: one decision per rising edge, in priority order.
    logic [63:0] m_pc, m_pcd;
    logic [31:0] m_instr, m_count;
    logic        m_valid, m_halt;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_pc <= '0; m_pcd <= '0; m_instr <= '0; m_valid <= 1'b0;
            m_count <= '0; m_halt <= 1'b0;
        end else if (PCSrc_F) begin
            m_pc <= {PCBranch_F[63:2], 2'b00};
            m_instr <= '0; m_pcd <= '0; m_valid <= 1'b0;
            m_halt <= 1'b0;
        end else if (m_halt || stall) begin
            if (m_halt || flush) begin
                m_instr <= '0; m_pcd <= '0; m_valid <= 1'b0;
            end
        end else if (mem[m_pc[7:2]] == 32'h0) begin
            m_halt <= 1'b1;
            m_instr <= '0; m_pcd <= '0; m_valid <= 1'b0;
        end else begin
            m_pc <= m_pc + 64'd4;
            if (flush) begin
                m_instr <= '0; m_pcd <= '0; m_valid <= 1'b0;
            end else begin
                m_instr <= mem[m_pc[7:2]];
                m_pcd   <= m_pc;
                m_valid <= 1'b1;
                m_count <= m_count + 32'd1;
            end
        end
    end

    // Compare process: outputs only move on the rising edge or reset.
    always @(negedge clk) begin
        chk("imem_addr", 64'(imem_addr), 64'(m_pc[7:2]));
        chk("pc_F", pc_F, m_pc);
        chk("instr_D", 64'(instr_D), 64'(m_instr));
        chk("pc_D", pc_D, m_pcd);
        chk("valid_D", 64'(valid_D), 64'(m_valid));
        chk("halted", 64'(halted), 64'(m_halt));
        chk("fetch_count", 64'(fetch_count), 64'(m_count));
    end

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'hC000_0000 | 32'(i);

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_pc_F", pc_F, 64'h0);
        chk("rst_valid_D", 64'(valid_D), 64'h0);
        chk("rst_fetch_count", 64'(fetch_count), 64'h0);
        chk("rst_halted", 64'(halted), 64'h0);
        chk("rst_imem_addr", 64'(imem_addr), 64'h0);
        #2 reset = 1'b0;

        // Sequential fetch, then two stalled cycles at pc_F=8
        @(negedge clk);
        chk("seq1_addr", 64'(imem_addr), 64'd1);
        chk("seq1_pc_D", pc_D, 64'd0);
        chk("seq1_instr", 64'(instr_D), 64'hC000_0000);
        chk("seq1_count", 64'(fetch_count), 64'd1);
        @(negedge clk);
        chk("seq2_addr", 64'(imem_addr), 64'd2);
        chk("seq2_pc_F", pc_F, 64'd8);
        chk("seq2_pc_D", pc_D, 64'd4);
        stall = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("stall_pc_F", pc_F, 64'd8);
            chk("stall_instr", 64'(instr_D), 64'hC000_0001);
            chk("stall_count", 64'(fetch_count), 64'd2);
        end
        stall = 1'b0;
        @(negedge clk);
        chk("resume_pc_F", pc_F, 64'd12);
        chk("resume_addr", 64'(imem_addr), 64'd3);
        chk("resume_pc_D", pc_D, 64'd8);
        chk("resume_count", 64'(fetch_count), 64'd3);

        // Redirect during stall, unaligned target
        PCSrc_F = 1'b1; PCBranch_F = 64'h4B; stall = 1'b1;
        @(negedge clk);
        chk("redir_pc_F", pc_F, 64'h48);
        chk("redir_valid", 64'(valid_D), 64'h0);
        chk("redir_addr", 64'(imem_addr), 64'd18);

        // Halt on a zero word at 0xBC, then leave via redirect to 0
        PCBranch_F = 64'hBC; stall = 1'b0;
        mem[47] = 32'h0;
        @(negedge clk);
        chk("pre_halt_pc_F", pc_F, 64'hBC);
        PCSrc_F = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("halt_halted", 64'(halted), 64'h1);
            chk("halt_pc_F", pc_F, 64'hBC);
            chk("halt_valid", 64'(valid_D), 64'h0);
            chk("halt_count", 64'(fetch_count), 64'd3);
        end
        PCSrc_F = 1'b1; PCBranch_F = 64'h0;
        @(negedge clk);
        chk("unhalt_halted", 64'(halted), 64'h0);
        chk("unhalt_pc_F", pc_F, 64'h0);
        PCSrc_F = 1'b0;
        mem[47] = 32'hC000_002F;
        repeat (16) @(negedge clk);
        chk("run16_pc_F", pc_F, 64'h40);
        chk("run16_count", 64'(fetch_count), 64'd19);

        // Asynchronous reset between edges
        #2 reset = 1'b1;
        #1;
        chk("async_pc_F", pc_F, 64'h0);
        chk("async_valid", 64'(valid_D), 64'h0);
        chk("async_count", 64'(fetch_count), 64'h0);
        chk("async_halted", 64'(halted), 64'h0);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("post_rst_pc_D", pc_D, 64'h0);
        chk("post_rst_valid", 64'(valid_D), 64'h1);

        // PC wrap at the top of the address space
        PCSrc_F = 1'b1; PCBranch_F = 64'hFFFF_FFFF_FFFF_FFFC;
        @(negedge clk);
        chk("wrap_pc_F", pc_F, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("wrap_addr", 64'(imem_addr), 64'd63);
        PCSrc_F = 1'b0;
        @(negedge clk);
        chk("wrapped_pc_F", pc_F, 64'h0);
        chk("wrapped_addr", 64'(imem_addr), 64'd0);
        chk("wrapped_pc_D", pc_D, 64'hFFFF_FFFF_FFFF_FFFC);

        // Randomized phase
        for (int c = 0; c < 3000; c++) begin
            PCSrc_F    = ($urandom_range(7) == 0);
            PCBranch_F = {$urandom, $urandom};
            if ($urandom_range(3) == 0) PCBranch_F[63:8] = '1;
            stall      = ($urandom_range(4) == 0);
            flush      = ($urandom_range(7) == 0);
            if ($urandom_range(15) == 0) begin
                int idx;
                idx = int'($urandom_range(63));
                mem[idx] = ($urandom_range(1) == 0) ? 32'h0 : ($urandom | 32'h1);
            end
            if ($urandom_range(299) == 0) begin
                #2 reset = 1'b1;
                #2 reset = 1'b0;
            end
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
